// File: rtl/gpio_input_conditioner.sv
// Pad input conditioning: a 2-flop synchroniser, then a per-pin debounce filter
// with registered rise/fall pulses that line up with the filtered level.

module gpio_ic_lane #(
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             sync_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] period_i,
  output logic             filt_o,
  output logic             rise_o,
  output logic             fall_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             filt_q, filt_d;
  logic             rise_q, fall_q;

  always_comb begin
    cnt_d  = cnt_q;
    filt_d = filt_q;
    if (!en_i) begin
      filt_d = sync_i;
      cnt_d  = '0;
    end else if (sync_i == filt_q) begin
      cnt_d  = '0;
    end else if (cnt_q >= period_i) begin
      // >= so that lowering the period mid-count finishes on the next mismatch
      filt_d = sync_i;
      cnt_d  = '0;
    end else begin
      cnt_d  = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      filt_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
      rise_q <= filt_d & ~filt_q;
      fall_q <= ~filt_d & filt_q;
    end
  end

  assign filt_o = filt_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;
endmodule

module gpio_input_conditioner #(
  parameter int IO_COUNT       = 16,
  parameter int DEBOUNCE_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [IO_COUNT-1:0]       pin_in,
  input  logic [IO_COUNT-1:0]       debounce_enable,
  input  logic [DEBOUNCE_WIDTH-1:0] debounce_period,
  output logic [IO_COUNT-1:0]       pin_filtered,
  output logic [IO_COUNT-1:0]       rise_pulse,
  output logic [IO_COUNT-1:0]       fall_pulse
);
  logic [IO_COUNT-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= pin_in;
      sync2_q <= sync1_q;
    end
  end

  for (genvar i = 0; i < IO_COUNT; i++) begin : g_pin
    gpio_ic_lane #(.CNT_W(DEBOUNCE_WIDTH)) u_lane (
      .clk_i    (clk),
      .rst_ni   (rst),
      .sync_i   (sync2_q[i]),
      .en_i     (debounce_enable[i]),
      .period_i (debounce_period),
      .filt_o   (pin_filtered[i]),
      .rise_o   (rise_pulse[i]),
      .fall_o   (fall_pulse[i])
    );
  end
endmodule
